// File: rtl/and_gate.sv
// Bitwise AND with a combinational output, plus a registered, valid-qualified copy,
// an all-ones flag and a saturating hit counter.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             count_clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             y_all,
    output logic [CNT_W-1:0] hit_count
);

    if (WIDTH < 1) begin : g_bad_width
        $error("and_gate: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("and_gate: CNT_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] and_c;
    logic             all_c;
    logic             hit_c;

    assign and_c = a & b;
    assign all_c = &and_c;
    assign hit_c = in_valid & all_c;
    assign y     = and_c;

    // Result capture: data and flag hold while idle, valid pulses per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_all     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q   <= and_c;
                y_all <= all_c;
            end
        end
    end

    // Hit counter: clear beats increment; stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (count_clr) begin
            hit_count <= '0;
        end else if (hit_c && (hit_count != CNT_MAX)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Directed self-checking bench for and_gate: gate truth table, registered path,
// hit counter saturation/clear, and asynchronous reset.
module tb_and_gate;

    logic clk;
    logic rst_n;

    // WIDTH=1, CNT_W=8
    logic       a1, b1, v1, c1;
    logic       y1, yq1, ov1, ya1;
    logic [7:0] hc1;

    // WIDTH=8, CNT_W=8
    logic [7:0] a8, b8, y8, yq8, hc8;
    logic       v8, c8, ov8, ya8;

    // WIDTH=8, CNT_W=2
    logic [7:0] a2, b2, y2, yq2;
    logic [1:0] hc2;
    logic       v2, c2, ov2, ya2;

    int n_tests;
    int n_fail;

    and_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .count_clr(c1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .y_all(ya1), .hit_count(hc1)
    );

    and_gate #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .count_clr(c8),
        .y(y8), .y_q(yq8), .out_valid(ov8), .y_all(ya8), .hit_count(hc8)
    );

    and_gate #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .in_valid(v2), .count_clr(c2),
        .y(y2), .y_q(yq2), .out_valid(ov2), .y_all(ya2), .hit_count(hc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       ta [4];
        logic       tb [4];
        logic       ty [4];
        logic [1:0] sat_exp [6];

        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; c1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b0; c8 = 1'b0;
        a2 = 8'h00; b2 = 8'h00; v2 = 1'b0; c2 = 1'b0;

        // Reset values, and y follows inputs during reset
        #3;
        chk("rst_y_q", 32'(yq8), 32'h0);
        chk("rst_out_valid", 32'(ov8), 32'h0);
        chk("rst_y_all", 32'(ya8), 32'h0);
        chk("rst_hit_count", 32'(hc8), 32'h0);
        chk("rst_hit_count_sat", 32'(hc2), 32'h0);
        a8 = 8'h0F; b8 = 8'hFF;
        #1;
        chk("rst_y_comb", 32'(y8), 32'h0F);

        #8;
        rst_n = 1'b1;
        tick();

        // Test 1: 2-input AND truth table
        ta[0] = 1'b0; tb[0] = 1'b0; ty[0] = 1'b0;
        ta[1] = 1'b0; tb[1] = 1'b1; ty[1] = 1'b0;
        ta[2] = 1'b1; tb[2] = 1'b0; ty[2] = 1'b0;
        ta[3] = 1'b1; tb[3] = 1'b1; ty[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = ta[i]; b1 = tb[i];
            #1;
            chk($sformatf("truth_%0d", i), 32'(y1), 32'(ty[i]));
            #9;
        end

        // Test 2: single accepted sample, 1-cycle latency and hold
        tick();
        a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
        #1;
        chk("t2_y_comb", 32'(y8), 32'h30);
        chk("t2_ov_before", 32'(ov8), 32'h0);
        tick();
        v8 = 1'b0;
        chk("t2_y_q", 32'(yq8), 32'h30);
        chk("t2_y_all", 32'(ya8), 32'h0);
        chk("t2_out_valid", 32'(ov8), 32'h1);
        chk("t2_hit_none", 32'(hc8), 32'h0);
        a8 = 8'h00; b8 = 8'h00;
        tick();
        chk("t2_ov_drop", 32'(ov8), 32'h0);
        chk("t2_y_q_hold", 32'(yq8), 32'h30);

        // Test 3: three all-ones samples then idle
        a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        tick();
        chk("t3_y_all", 32'(ya8), 32'h1);
        chk("t3_hit1", 32'(hc8), 32'h1);
        tick();
        chk("t3_hit2", 32'(hc8), 32'h2);
        chk("t3_ov_cont", 32'(ov8), 32'h1);
        tick();
        chk("t3_hit3", 32'(hc8), 32'h3);
        v8 = 1'b0;
        tick();
        chk("t3_hit_hold", 32'(hc8), 32'h3);
        chk("t3_ov_idle", 32'(ov8), 32'h0);
        chk("t3_y_all_hold", 32'(ya8), 32'h1);

        // Test 4: CNT_W=2 saturation
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;
        a2 = 8'hFF; b2 = 8'hFF; v2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4_sat_%0d", i), 32'(hc2), 32'(sat_exp[i]));
        end
        v2 = 1'b0;

        // Test 5: clear wins over a simultaneous hit
        c8 = 1'b1;
        tick();
        chk("t5_clr", 32'(hc8), 32'h0);
        c8 = 1'b0; v8 = 1'b1;
        tick();
        tick();
        chk("t5_pre", 32'(hc8), 32'h2);
        c8 = 1'b1;
        tick();
        chk("t5_clr_vs_hit", 32'(hc8), 32'h0);
        c8 = 1'b0; v8 = 1'b0;

        // Test 6: asynchronous reset between edges
        v8 = 1'b1;
        tick();
        chk("t6_pre_y_q", 32'(yq8), 32'hFF);
        chk("t6_pre_hit", 32'(hc8), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_y_q", 32'(yq8), 32'h0);
        chk("t6_rst_ov", 32'(ov8), 32'h0);
        chk("t6_rst_y_all", 32'(ya8), 32'h0);
        chk("t6_rst_hit", 32'(hc8), 32'h0);
        a8 = 8'hA5; b8 = 8'h0F;
        #1;
        chk("t6_rst_y_comb", 32'(y8), 32'h05);
        v8 = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t6_fresh_ov", 32'(ov8), 32'h0);
        chk("t6_fresh_y_q", 32'(yq8), 32'h0);
        a8 = 8'h3C; b8 = 8'h3C; v8 = 1'b1;
        tick();
        chk("t6_after_y_q", 32'(yq8), 32'h3C);
        chk("t6_after_ov", 32'(ov8), 32'h1);
        chk("t6_after_hit", 32'(hc8), 32'h0);
        v8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
